// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: beat-driven x/y counters with registered syncs, video_on and line/frame strobes.
// Define VGA_SYNC_BEAT_EN to advance only on beat cycles; otherwise every clk is a beat.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       beat,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] L_H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] L_H_FP   = 10'(H_ACTIVE);
  localparam logic [9:0] L_H_SY   = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] L_H_BP   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] L_V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] L_V_FP   = 10'(V_ACTIVE);
  localparam logic [9:0] L_V_SY   = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] L_V_BP   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic [1:0] S_ACT  = 2'd0;
  localparam logic [1:0] S_FP   = 2'd1;
  localparam logic [1:0] S_SYNC = 2'd2;
  localparam logic [1:0] S_BP   = 2'd3;

  logic       w_beat;
  logic       w_x_wrap;
  logic [9:0] w_x_nxt, w_y_nxt;
  logic [1:0] w_hs_nxt, w_vs_nxt;

  logic [9:0] r_x, r_y;
  logic [1:0] r_hs, r_vs;
  logic       r_hsync, r_vsync, r_video, r_ls, r_fs;

`ifdef VGA_SYNC_BEAT_EN
  assign w_beat = beat;
`else
  assign w_beat = beat | 1'b1;
`endif

  // Later phases are tested first so a zero-width porch falls through to the next phase.
  always_comb begin
    w_x_wrap = (r_x == L_H_LAST);
    w_x_nxt  = w_x_wrap ? 10'd0 : r_x + 10'd1;
    w_y_nxt  = r_y;
    if (w_x_wrap) w_y_nxt = (r_y == L_V_LAST) ? 10'd0 : r_y + 10'd1;

    w_hs_nxt = r_hs;
    if      (w_x_nxt == L_H_BP) w_hs_nxt = S_BP;
    else if (w_x_nxt == L_H_SY) w_hs_nxt = S_SYNC;
    else if (w_x_nxt == L_H_FP) w_hs_nxt = S_FP;
    else if (w_x_nxt == 10'd0)  w_hs_nxt = S_ACT;

    w_vs_nxt = r_vs;
    if (w_x_wrap) begin
      if      (w_y_nxt == L_V_BP) w_vs_nxt = S_BP;
      else if (w_y_nxt == L_V_SY) w_vs_nxt = S_SYNC;
      else if (w_y_nxt == L_V_FP) w_vs_nxt = S_FP;
      else if (w_y_nxt == 10'd0)  w_vs_nxt = S_ACT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x     <= L_H_LAST;
      r_y     <= L_V_LAST;
      r_hs    <= S_BP;
      r_vs    <= S_BP;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_video <= 1'b0;
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_ls <= 1'b0;
      r_fs <= 1'b0;
      if (w_beat) begin
        r_x     <= w_x_nxt;
        r_y     <= w_y_nxt;
        r_hs    <= w_hs_nxt;
        r_vs    <= w_vs_nxt;
        r_hsync <= (w_hs_nxt == S_SYNC) ? SYNC_POL : ~SYNC_POL;
        r_vsync <= (w_vs_nxt == S_SYNC) ? SYNC_POL : ~SYNC_POL;
        r_video <= (w_hs_nxt == S_ACT) && (w_vs_nxt == S_ACT);
        r_ls    <= (w_x_nxt == 10'd0);
        r_fs    <= (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
      end
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video;
  assign line_start  = r_ls;
  assign frame_start = r_fs;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a default 640x480 instance plus a tiny-raster instance for whole-frame checks.
// Expectations follow whichever build is compiled (VGA_SYNC_BEAT_EN defined or not).
module tb_vga_sync_gen;
`ifdef VGA_SYNC_BEAT_EN
  localparam bit BEAT_EN = 1'b1;
`else
  localparam bit BEAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic beat = 1'b0;

  logic       hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] x, y;
  logic       s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
  logic [9:0] s_x, s_y;

  int total = 0;
  int bad = 0;
  // expected positions: default raster (ex,ey) and tiny raster 15x12 (sx,sy)
  int ex = 799, ey = 524, sx = 14, sy = 11;
  bit adv = 1'b0;

  always #5 clk = ~clk;

  vga_sync_gen u_dut (
    .clk(clk), .reset(reset), .beat(beat), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .reset(reset), .beat(beat), .hsync(s_hsync), .vsync(s_vsync),
    .video_on(s_video_on), .x(s_x), .y(s_y), .line_start(s_line_start), .frame_start(s_frame_start)
  );

  // One clk with the given beat; outputs sampled 1 time unit after the edge.
  task automatic tick(input logic b);
    beat = b;
    @(posedge clk);
    #1;
    adv = !reset && (BEAT_EN ? b : 1'b1);
    if (reset) begin
      ex = 799; ey = 524; sx = 14; sy = 11;
    end else if (adv) begin
      if (ex == 799) begin ex = 0; ey = (ey == 524) ? 0 : ey + 1; end
      else ex = ex + 1;
      if (sx == 14) begin sx = 0; sy = (sy == 11) ? 0 : sy + 1; end
      else sx = sx + 1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick(1'b1);
    total++; if (x !== 10'd799) begin bad++; $display("FAIL reset_x got=%0d exp=799", x); end
    total++; if (y !== 10'd524) begin bad++; $display("FAIL reset_y got=%0d exp=524", y); end
    total++; if (hsync !== 1'b1 || vsync !== 1'b1) begin bad++; $display("FAIL reset_sync got=%b%b exp=11", hsync, vsync); end
    total++; if (video_on !== 1'b0) begin bad++; $display("FAIL reset_video got=%b exp=0", video_on); end
    total++; if (line_start !== 1'b0 || frame_start !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b exp=00", line_start, frame_start); end
    total++; if (s_x !== 10'd14 || s_y !== 10'd11) begin bad++; $display("FAIL reset_small got=%0d,%0d exp=14,11", s_x, s_y); end
    reset = 1'b0;
    tick(1'b1);
    total++; if (x !== 10'd0 || y !== 10'd0) begin bad++; $display("FAIL first_beat_pos got=%0d,%0d exp=0,0", x, y); end
    total++; if (video_on !== 1'b1) begin bad++; $display("FAIL first_beat_video got=%b exp=1", video_on); end
    total++; if (line_start !== 1'b1 || frame_start !== 1'b1) begin bad++; $display("FAIL first_beat_strobes got=%b%b exp=11", line_start, frame_start); end
    tick(1'b1);
    total++; if (x !== 10'd1) begin bad++; $display("FAIL second_beat_x got=%0d exp=1", x); end
    total++; if (line_start !== 1'b0 || frame_start !== 1'b0) begin bad++; $display("FAIL strobe_width got=%b%b exp=00", line_start, frame_start); end
  endtask

  task automatic test_beat_spacing;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1);
      total++; if (x !== 10'(ex)) begin bad++; $display("FAIL spaced_beat_x got=%0d exp=%0d", x, ex); end
      for (int j = 0; j < 3; j++) begin
        tick(1'b0);
        total++; if (x !== 10'(ex)) begin bad++; $display("FAIL spaced_idle_x got=%0d exp=%0d", x, ex); end
        total++; if (line_start !== (adv && ex == 0)) begin bad++; $display("FAIL spaced_idle_ls got=%b exp=%b", line_start, adv && ex == 0); end
      end
    end
    if (BEAT_EN) begin
      total++; if (x !== 10'd9) begin bad++; $display("FAIL spaced_final_x got=%0d exp=9", x); end
    end else begin
      total++; if (x !== 10'd33) begin bad++; $display("FAIL spaced_final_x got=%0d exp=33", x); end
    end
  endtask

  task automatic test_line;
    int ly;
    ly = ey;
    for (int i = 0; i < 810; i++) begin
      tick(1'b1);
      total++; if (x !== 10'(ex) || y !== 10'(ey)) begin bad++; $display("FAIL line_pos got=%0d,%0d exp=%0d,%0d", x, y, ex, ey); end
      total++; if (hsync !== !(ex >= 656 && ex <= 751)) begin bad++; $display("FAIL line_hsync x=%0d got=%b exp=%b", ex, hsync, !(ex >= 656 && ex <= 751)); end
      total++; if (vsync !== !(ey >= 490 && ey <= 491)) begin bad++; $display("FAIL line_vsync y=%0d got=%b", ey, vsync); end
      total++; if (video_on !== (ex < 640 && ey < 480)) begin bad++; $display("FAIL line_video x=%0d got=%b exp=%b", ex, video_on, ex < 640 && ey < 480); end
      total++; if (line_start !== (ex == 0)) begin bad++; $display("FAIL line_ls x=%0d got=%b exp=%b", ex, line_start, ex == 0); end
      total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL line_fs x=%0d got=%b exp=0", ex, frame_start); end
    end
    total++; if (y !== 10'(ly + 1)) begin bad++; $display("FAIL line_y_inc got=%0d exp=%0d", y, ly + 1); end
  endtask

  task automatic test_frame;
    int fs_cnt, vs_low;
    fs_cnt = 0; vs_low = 0;
    for (int i = 0; i < 180; i++) begin
      tick(1'b1);
      if (s_frame_start === 1'b1) fs_cnt++;
      if (s_vsync === 1'b0) vs_low++;
      total++; if (s_x !== 10'(sx) || s_y !== 10'(sy)) begin bad++; $display("FAIL frame_pos got=%0d,%0d exp=%0d,%0d", s_x, s_y, sx, sy); end
      total++; if (s_vsync !== !(sy >= 7 && sy <= 8)) begin bad++; $display("FAIL frame_vsync y=%0d got=%b", sy, s_vsync); end
      total++; if (s_hsync !== !(sx >= 10 && sx <= 12)) begin bad++; $display("FAIL frame_hsync x=%0d got=%b", sx, s_hsync); end
      total++; if (s_frame_start !== (sx == 0 && sy == 0)) begin bad++; $display("FAIL frame_fs pos=%0d,%0d got=%b", sx, sy, s_frame_start); end
    end
    total++; if (fs_cnt != 1) begin bad++; $display("FAIL frame_fs_count got=%0d exp=1", fs_cnt); end
    total++; if (vs_low != 30) begin bad++; $display("FAIL frame_vsync_beats got=%0d exp=30", vs_low); end
  endtask

  task automatic test_midreset;
    int guard;
    guard = 0;
    while (ex != 300 && guard < 2000) begin tick(1'b1); guard++; end
    total++; if (x !== 10'd300) begin bad++; $display("FAIL midreset_setup got=%0d exp=300", x); end
    reset = 1'b1;
    tick(1'b1);
    total++; if (x !== 10'd799 || y !== 10'd524) begin bad++; $display("FAIL midreset_pos got=%0d,%0d exp=799,524", x, y); end
    total++; if (hsync !== 1'b1 || vsync !== 1'b1 || video_on !== 1'b0) begin bad++; $display("FAIL midreset_outs got=%b%b%b exp=110", hsync, vsync, video_on); end
    total++; if (line_start !== 1'b0 || frame_start !== 1'b0) begin bad++; $display("FAIL midreset_strobes got=%b%b exp=00", line_start, frame_start); end
    total++; if (s_x !== 10'd14 || s_y !== 10'd11) begin bad++; $display("FAIL midreset_small got=%0d,%0d exp=14,11", s_x, s_y); end
    reset = 1'b0;
  endtask

  task automatic test_beat_tied_low;
    for (int i = 0; i < 20; i++) tick(1'b0);
    if (BEAT_EN) begin
      total++; if (x !== 10'd799 || y !== 10'd524) begin bad++; $display("FAIL tied_low_pos got=%0d,%0d exp=799,524", x, y); end
    end else begin
      total++; if (x !== 10'd19 || y !== 10'd0) begin bad++; $display("FAIL tied_low_pos got=%0d,%0d exp=19,0", x, y); end
    end
    total++; if (line_start !== 1'b0) begin bad++; $display("FAIL tied_low_ls got=%b exp=0", line_start); end
  endtask

  initial begin
    test_reset();
    test_beat_spacing();
    test_line();
    test_frame();
    test_midreset();
    test_beat_tied_low();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA raster timing generator that consumes the one-cycle `beat` pixel-enable strobe from the clock divider. It advances horizontal and vertical position counters once per beat and produces registered hsync/vsync, video-active, pixel coordinates and line/frame start strobes. It sits between the clock divider and the pixel/colour logic of the VGA driver.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, asserted level of hsync/vsync (0 = active-low)
- `clk` input 1: the single clock; every register updates on its rising edge.
- `reset` input 1: synchronous, active-high; sampled on the `clk` rising edge.
- `beat` input 1: pixel-enable strobe. A cycle with `beat` high is one pixel step.
- `hsync` output 1: horizontal sync, level `SYNC_POL` when asserted.
- `vsync` output 1: vertical sync, level `SYNC_POL` when asserted.
- `video_on` output 1: current position is inside the visible area.
- `x` output 10: current horizontal count, 0..H_TOTAL-1.
- `y` output 10: current vertical count, 0..V_TOTAL-1.
- `line_start` output 1: one-clk pulse when `x` becomes 0.
- `frame_start` output 1: one-clk pulse when (`x`,`y`) becomes (0,0).

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (default 800). V_TOTAL is the vertical equivalent (default 525). Both totals must be ≤ 1024. All arithmetic is unsigned 10-bit.
- Horizontal FSM states: H_ACT [0, H_ACTIVE-1], H_FP, H_SYNC, H_BP, in that order, then back to H_ACT. The state changes only on beat cycles, at the phase-boundary counts.
- Vertical FSM states: V_ACT, V_FP, V_SYNC, V_BP, with the same structure. It advances only on a beat cycle where `x` wraps from H_TOTAL-1 to 0.
- On a beat cycle:
  - `x` increments. At H_TOTAL-1 it wraps to 0.
  - On that wrap, `y` increments. At V_TOTAL-1 it wraps to 0.
- `hsync` = SYNC_POL iff the new x is in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1]; otherwise ~SYNC_POL. `vsync` follows the same rule on y.
- `video_on` = (new x < H_ACTIVE) && (new y < V_ACTIVE).
- `line_start` is 1 only on the beat cycle where new x = 0. `frame_start` additionally requires new y = 0. Both return to 0 on the next clk, regardless of `beat`.
- Non-beat cycles: x, y, FSM state, hsync, vsync and video_on hold. The strobes are 0.
- Reset values:
  - x = H_TOTAL-1 (799), y = V_TOTAL-1 (524)
  - both FSMs in their BP state
  - hsync = vsync = ~SYNC_POL, video_on = 0, line_start = frame_start = 0
- Consequence of the reset values: the first beat after reset produces (0,0), frame_start, line_start and video_on = 1.
- Reset asserted mid-frame overrides `beat` and restores the reset values on that edge. There is no partial-line completion.

## Timing
- Every output is a register. Outputs describe the new position on the same `clk` edge that samples `beat` high. Latency beat→outputs is 0 clk after the sampling edge.
- Back-to-back beats (beat high every cycle) are legal and advance one position per clk.
- No minimum beat spacing is required. No `beat` is ever dropped or double-counted.
- The strobes are exactly one `clk` wide, even when `beat` stays high.

## Configuration
- `VGA_SYNC_BEAT_EN`:
  - Defined: counters advance only on cycles with `beat` high, as described above.
  - Undefined: `beat` is ignored (the port remains) and every `clk` cycle is treated as a beat cycle.
  - All other behaviour, reset values and widths are identical in both builds.

## Test plan
- Reset for 3 clk with default parameters → hsync=1, vsync=1, video_on=0, x=799, y=524, strobes 0. First beat → x=0, y=0, video_on=1, line_start=frame_start=1 for 1 clk.
- Beat every 4th clk → x advances by 1 per beat and holds between beats. line_start is never high on non-beat cycles.
- Count across a line → hsync goes 0 on the beat where x becomes 656 and returns to 1 where x becomes 752. video_on goes 0 at x=640. At x 799→0, y increments and line_start pulses.
- Run one full frame (420000 beats) → vsync is low for exactly y=490..491. frame_start pulses exactly once, at the wrap 524→0.
- Assert reset at x=300, y=100 with beat high → the next edge gives x=799, y=524, outputs at reset values.
- Build without VGA_SYNC_BEAT_EN, beat tied 0 → x advances every clk. The frame period is 420000 clk.
